led_strip_driver: RTL

Parametrised frame serialiser for clocked two-wire RGB strips (data + clock, WS2801-class). It accepts a per-bin colour and LED count from the visualiser and expands the bins into exactly `LEDS` pixels, skipping empty bins and padding short frames. Each pixel is shifted out MSB-first at a programmable serial rate, and every frame ends with a timed latch gap. It sits between the linear visualiser and the strip pins, and replaces the fixed-width 24-bit driver.

---
 rtl/led_pkg.sv | 28 ++
 rtl/led_bin_expander.sv | 66 ++++++
 rtl/led_strip_driver.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/led_pkg.sv
// Shared types and helpers for the clocked two-wire LED strip driver.
package led_pkg;

    typedef enum logic [2:0] {
        ST_RSTLATCH,
        ST_IDLE,
        ST_FETCH,
        ST_SHIFT,
        ST_LATCH
    } state_t;

    localparam int CHANNELS = 3;
    localparam int MAX_CH_W = 16;

    // (c * (bright + 1)) >> 8, kept to ch_w bits; bright = 255 is identity.
    function automatic logic [MAX_CH_W-1:0] scale_channel(
        input int                  ch_w,
        input logic [MAX_CH_W-1:0] c,
        input logic [7:0]          bright
    );
        logic [MAX_CH_W+8:0] prod;
        logic [MAX_CH_W-1:0] mask;
        prod = {9'd0, c} * ({{MAX_CH_W{1'b0}}, 1'b0, bright} + {{(MAX_CH_W+8){1'b0}}, 1'b1});
        mask = MAX_CH_W'((32'd1 << ch_w) - 32'd1);
        return prod[MAX_CH_W+7:8] & mask;
    endfunction

endpackage

// File: rtl/led_bin_expander.sv
// Expands per-bin colours and counts into a per-pixel colour stream:
// skips empty bins, holds the last colour once counts run out.
module led_bin_expander
    import led_pkg::*;
#(
    parameter int LEDS    = 50,
    parameter int BIN_QTY = 12,
    parameter int CH_W    = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 load,
    input  logic                                 advance,
    input  logic [BIN_QTY*CHANNELS*CH_W-1:0]     rgb,
    input  logic [BIN_QTY*$clog2(LEDS+1)-1:0]    led_counts,
    output logic [CHANNELS*CH_W-1:0]             pixel
);

    localparam int PIX_W = CHANNELS * CH_W;
    localparam int CNT_W = $clog2(LEDS + 1);
    localparam int BIN_W = (BIN_QTY > 1) ? $clog2(BIN_QTY) : 1;

    logic [CNT_W-1:0] remaining [BIN_QTY];
    logic [PIX_W-1:0] colour    [BIN_QTY];
    logic [PIX_W-1:0] last_colour;
    logic [BIN_W-1:0] ptr;
    logic [BIN_W-1:0] cur_bin;
    logic             found;

    // Lowest bin at or after ptr that still has pixels to give.
    always_comb begin
        found   = 1'b0;
        cur_bin = '0;
        for (int i = BIN_QTY - 1; i >= 0; i--) begin
            if (i >= int'(ptr) && remaining[i] != '0) begin
                found   = 1'b1;
                cur_bin = BIN_W'(i);
            end
        end
    end

    assign pixel = found ? colour[cur_bin] : last_colour;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr         <= '0;
            last_colour <= '0;
            for (int i = 0; i < BIN_QTY; i++) begin
                remaining[i] <= '0;
                colour[i]    <= '0;
            end
        end else if (load) begin
            ptr         <= '0;
            last_colour <= '0;
            for (int i = 0; i < BIN_QTY; i++) begin
                remaining[i] <= led_counts[i*CNT_W +: CNT_W];
                colour[i]    <= rgb[i*PIX_W +: PIX_W];
            end
        end else if (advance && found) begin
            remaining[cur_bin] <= remaining[cur_bin] - CNT_W'(1);
            ptr                <= cur_bin;
            last_colour        <= colour[cur_bin];
        end
    end

endmodule

// File: rtl/led_strip_driver.sv
// Frame serialiser for WS2801-class strips: bin expansion, MSB-first shift, latch gap.
// Define LED_BRIGHT_EN to scale every channel by the captured global brightness.
module led_strip_driver
    import led_pkg::*;
#(
    parameter int LEDS         = 50,
    parameter int BIN_QTY      = 12,
    parameter int CH_W         = 8,
    parameter int CLK_DIV      = 2,
    parameter int LATCH_CYCLES = 6250
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic [BIN_QTY*3*CH_W-1:0]          rgb,
    input  logic [BIN_QTY*$clog2(LEDS+1)-1:0]  led_counts,
    input  logic [7:0]                         bright,
    output logic                               sclk,
    output logic                               sdata,
    output logic                               busy,
    output logic                               done
);

    localparam int PIX_W     = CHANNELS * CH_W;
    localparam int PIX_CNT_W = (LEDS > 1) ? $clog2(LEDS) : 1;
    localparam int BIT_W     = $clog2(PIX_W);
    localparam int DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int LAT_W     = (LATCH_CYCLES > 0) ? $clog2(LATCH_CYCLES + 1) : 1;

    state_t               state;
    state_t               next_state;
    logic [PIX_CNT_W-1:0] pix_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DIV_W-1:0]     div_cnt;
    logic                 phase;
    logic [LAT_W-1:0]     lat_cnt;
    logic [PIX_W-1:0]     shreg;
    logic [PIX_W-1:0]     pixel;
    logic [PIX_W-1:0]     fetch_colour;
    logic                 half_end;
    logic                 pixel_end;
    logic                 lat_end;
    logic                 load;
    logic                 sclk_d;
    logic                 sdata_d;
    logic                 busy_d;
    logic                 done_d;

    assign load      = (state == ST_IDLE) && start;
    assign half_end  = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign pixel_end = (state == ST_SHIFT) && phase && half_end && (bit_cnt == BIT_W'(PIX_W - 1));
    assign lat_end   = (lat_cnt == LAT_W'(LATCH_CYCLES));

    led_bin_expander #(
        .LEDS    (LEDS),
        .BIN_QTY (BIN_QTY),
        .CH_W    (CH_W)
    ) u_expander (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .advance    (state == ST_FETCH),
        .rgb        (rgb),
        .led_counts (led_counts),
        .pixel      (pixel)
    );

`ifdef LED_BRIGHT_EN
    logic [7:0] bright_r;

    always_ff @(posedge clk) begin
        if (rst)       bright_r <= '0;
        else if (load) bright_r <= bright;
    end

    always_comb begin
        fetch_colour = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            fetch_colour[c*CH_W +: CH_W] =
                CH_W'(scale_channel(CH_W, MAX_CH_W'(pixel[c*CH_W +: CH_W]), bright_r));
        end
    end
`else
    logic unused_bright;
    assign unused_bright = ^bright;
    assign fetch_colour  = pixel;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= ST_RSTLATCH;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_RSTLATCH: if (lat_end) next_state = ST_IDLE;
            ST_IDLE:     if (start)   next_state = ST_FETCH;
            ST_FETCH:    next_state = ST_SHIFT;
            ST_SHIFT:    if (pixel_end)
                             next_state = (pix_cnt == PIX_CNT_W'(LEDS - 1)) ? ST_LATCH : ST_FETCH;
            ST_LATCH:    if (lat_end) next_state = ST_IDLE;
            default:     next_state = ST_RSTLATCH;
        endcase
    end

    // Pins are registered one cycle behind the state, so the latch state runs
    // LATCH_CYCLES+1 cycles to give LATCH_CYCLES low cycles on the pins.
    always_comb begin
        sclk_d  = (state == ST_SHIFT) && phase;
        sdata_d = 1'b0;
        if (state == ST_SHIFT)      sdata_d = shreg[PIX_W-1];
        else if (state == ST_FETCH) sdata_d = sdata;
        busy_d  = (next_state != ST_IDLE);
        done_d  = (state == ST_LATCH) && (next_state == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pix_cnt <= '0;
            bit_cnt <= '0;
            div_cnt <= '0;
            phase   <= 1'b0;
            lat_cnt <= '0;
            shreg   <= '0;
            sclk    <= 1'b0;
            sdata   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            sclk  <= sclk_d;
            sdata <= sdata_d;
            busy  <= busy_d;
            done  <= done_d;
            if ((state == ST_RSTLATCH || state == ST_LATCH) && next_state == state)
                lat_cnt <= lat_cnt + LAT_W'(1);
            else
                lat_cnt <= '0;
            case (state)
                ST_IDLE: if (start) pix_cnt <= '0;
                ST_FETCH: begin
                    shreg   <= fetch_colour;
                    bit_cnt <= '0;
                    div_cnt <= '0;
                    phase   <= 1'b0;
                end
                ST_SHIFT: begin
                    if (!half_end) begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end else begin
                        div_cnt <= '0;
                        if (!phase) begin
                            phase <= 1'b1;
                        end else begin
                            phase <= 1'b0;
                            shreg <= shreg << 1;
                            if (bit_cnt != BIT_W'(PIX_W - 1))
                                bit_cnt <= bit_cnt + BIT_W'(1);
                            else if (pix_cnt != PIX_CNT_W'(LEDS - 1))
                                pix_cnt <= pix_cnt + PIX_CNT_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
